// File: rtl/flash_op_sequencer_if.sv
// Command/trigger/busy bus between the flash op sequencer (master) and the
// quad-flash memory controller (slave).
interface flash_op_sequencer_if;
    logic [7:0]  MEMCMD;
    logic [23:0] MEMADDR;
    logic [23:0] MEMVAL;
    logic        MEMQUAD;
    logic        MEMTRIG;
    logic        MEM_CTRL_busy;
    logic [47:0] MEMDATA;

    modport master (
        output MEMCMD, MEMADDR, MEMVAL, MEMQUAD, MEMTRIG,
        input  MEM_CTRL_busy, MEMDATA
    );

    modport slave (
        input  MEMCMD, MEMADDR, MEMVAL, MEMQUAD, MEMTRIG,
        output MEM_CTRL_busy, MEMDATA
    );
endinterface

// File: rtl/flash_op_sequencer.sv
// Sequences RDID/RSR1/sector-erase/bulk-erase over the memory controller handshake.
// Optional WEL verification after WREN is enabled by defining FLASH_SEQ_WEL_CHECK_EN.
module flash_op_sequencer #(
    parameter int          BUSY_TIMEOUT = 16,
    parameter int          POLL_GAP     = 64,
    parameter logic [23:0] POLL_LIMIT   = 24'hFFFFFF,
    parameter int          WEL_RETRIES  = 3,
    parameter int          WIP_BIT      = 0,
    parameter int          WEL_BIT      = 1
) (
    input  logic                 CLK,
    input  logic                 reset_n,
    input  logic                 op_req,
    input  logic [1:0]           op_code,
    input  logic [23:0]          op_addr,
    output logic                 seq_busy,
    output logic                 op_done,
    output logic                 op_error,
    output logic [47:0]          op_result,
    flash_op_sequencer_if.master mem
);
    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_DECIDE, S_GAP, S_FINISH
    } state_t;

    typedef enum logic [2:0] {
        STEP_SINGLE, STEP_WREN, STEP_WELCHK, STEP_ERASE, STEP_POLL
    } step_t;

    if (WEL_RETRIES < 1 || WEL_RETRIES > 3 || WIP_BIT > 7 || WEL_BIT > 7 ||
        BUSY_TIMEOUT < 1 || POLL_GAP < 1) begin : g_param_check
        $error("flash_op_sequencer: parameter out of range");
    end

    state_t      state_reg;
    step_t       step_reg;
    logic        code_lsb_reg;
    logic [23:0] addr_reg;
    logic [47:0] data_reg;
    logic [15:0] ack_cnt_reg;
    logic [15:0] gap_cnt_reg;
    logic [23:0] poll_cnt_reg;
    logic [23:0] poll_cnt_next;
`ifdef FLASH_SEQ_WEL_CHECK_EN
    logic [1:0]  wel_cnt_reg;
`endif
    logic [7:0]  memcmd_reg;
    logic [23:0] memaddr_reg;
    logic        memtrig_reg;
    logic        seq_busy_reg;
    logic        op_done_reg;
    logic        op_error_reg;
    logic [47:0] op_result_reg;
    logic [7:0]  issue_cmd;
    logic [23:0] issue_addr;

    assign poll_cnt_next = poll_cnt_reg + 24'd1;

    // code_lsb distinguishes RDID/RSR1 for single ops and SE/BE for erases.
    always_comb begin
        issue_cmd  = 8'h05;
        issue_addr = '0;
        case (step_reg)
            STEP_SINGLE: issue_cmd = code_lsb_reg ? 8'h05 : 8'h9F;
            STEP_WREN:   issue_cmd = 8'h06;
            STEP_ERASE: begin
                if (code_lsb_reg) begin
                    issue_cmd = 8'hC7;
                end else begin
                    issue_cmd  = 8'hD8;
                    issue_addr = addr_reg;
                end
            end
            default:     issue_cmd = 8'h05;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            state_reg     <= S_IDLE;
            step_reg      <= STEP_SINGLE;
            code_lsb_reg  <= 1'b0;
            addr_reg      <= '0;
            data_reg      <= '0;
            ack_cnt_reg   <= '0;
            gap_cnt_reg   <= '0;
            poll_cnt_reg  <= '0;
`ifdef FLASH_SEQ_WEL_CHECK_EN
            wel_cnt_reg   <= '0;
`endif
            memcmd_reg    <= '0;
            memaddr_reg   <= '0;
            memtrig_reg   <= 1'b0;
            seq_busy_reg  <= 1'b0;
            op_done_reg   <= 1'b0;
            op_error_reg  <= 1'b0;
            op_result_reg <= '0;
        end else begin
            op_done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    // op_done_reg blocks an accept in the completion cycle.
                    if (op_req && !mem.MEM_CTRL_busy && !op_done_reg) begin
                        code_lsb_reg <= op_code[0];
                        addr_reg     <= op_addr;
                        step_reg     <= op_code[1] ? STEP_WREN : STEP_SINGLE;
                        seq_busy_reg <= 1'b1;
                        op_error_reg <= 1'b0;
                        poll_cnt_reg <= '0;
`ifdef FLASH_SEQ_WEL_CHECK_EN
                        wel_cnt_reg  <= '0;
`endif
                        state_reg    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    memcmd_reg  <= issue_cmd;
                    memaddr_reg <= issue_addr;
                    memtrig_reg <= 1'b1;
                    ack_cnt_reg <= '0;
                    state_reg   <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (mem.MEM_CTRL_busy) begin
                        memtrig_reg <= 1'b0;
                        state_reg   <= S_WAIT_DONE;
                    end else if (ack_cnt_reg == 16'(BUSY_TIMEOUT - 1)) begin
                        memtrig_reg  <= 1'b0;
                        op_error_reg <= 1'b1;
                        state_reg    <= S_FINISH;
                    end else begin
                        ack_cnt_reg <= ack_cnt_reg + 16'd1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!mem.MEM_CTRL_busy) begin
                        data_reg  <= mem.MEMDATA;
                        state_reg <= S_DECIDE;
                    end
                end
                S_DECIDE: begin
                    case (step_reg)
                        STEP_SINGLE: state_reg <= S_FINISH;
                        STEP_WREN: begin
`ifdef FLASH_SEQ_WEL_CHECK_EN
                            step_reg <= STEP_WELCHK;
`else
                            step_reg <= STEP_ERASE;
`endif
                            state_reg <= S_ISSUE;
                        end
`ifdef FLASH_SEQ_WEL_CHECK_EN
                        STEP_WELCHK: begin
                            if (data_reg[WEL_BIT]) begin
                                step_reg  <= STEP_ERASE;
                                state_reg <= S_ISSUE;
                            end else if (int'({30'd0, wel_cnt_reg}) + 1 < WEL_RETRIES) begin
                                wel_cnt_reg <= wel_cnt_reg + 2'd1;
                                step_reg    <= STEP_WREN;
                                state_reg   <= S_ISSUE;
                            end else begin
                                op_error_reg <= 1'b1;
                                state_reg    <= S_FINISH;
                            end
                        end
`endif
                        STEP_ERASE: begin
                            step_reg    <= STEP_POLL;
                            gap_cnt_reg <= '0;
                            state_reg   <= S_GAP;
                        end
                        default: begin
                            if (!data_reg[WIP_BIT]) begin
                                state_reg <= S_FINISH;
                            end else begin
                                poll_cnt_reg <= poll_cnt_next;
                                if (poll_cnt_next == POLL_LIMIT) begin
                                    op_error_reg <= 1'b1;
                                    state_reg    <= S_FINISH;
                                end else begin
                                    gap_cnt_reg <= '0;
                                    state_reg   <= S_GAP;
                                end
                            end
                        end
                    endcase
                end
                S_GAP: begin
                    if (gap_cnt_reg == 16'(POLL_GAP - 1)) begin
                        state_reg <= S_ISSUE;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + 16'd1;
                    end
                end
                S_FINISH: begin
                    op_result_reg <= data_reg;
                    op_done_reg   <= 1'b1;
                    seq_busy_reg  <= 1'b0;
                    state_reg     <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign seq_busy    = seq_busy_reg;
    assign op_done     = op_done_reg;
    assign op_error    = op_error_reg;
    assign op_result   = op_result_reg;
    assign mem.MEMCMD  = memcmd_reg;
    assign mem.MEMADDR = memaddr_reg;
    assign mem.MEMTRIG = memtrig_reg;
    assign mem.MEMVAL  = '0;
    assign mem.MEMQUAD = 1'b0;
endmodule

// File: tb/tb_flash_op_sequencer.sv
// Directed bench for flash_op_sequencer with a behavioural memory-controller model.
// Expected command orders follow FLASH_SEQ_WEL_CHECK_EN when it is defined.
module tb_flash_op_sequencer;
    localparam int POLL_GAP     = 64;
    localparam int BUSY_TIMEOUT = 16;

    logic        CLK = 1'b0;
    logic        reset_n = 1'b0;
    logic        op_req = 1'b0;
    logic [1:0]  op_code = 2'b00;
    logic [23:0] op_addr = 24'h0;
    logic        seq_busy, op_done, op_error;
    logic [47:0] op_result;

    flash_op_sequencer_if mem_if ();

    flash_op_sequencer #(
        .BUSY_TIMEOUT(BUSY_TIMEOUT),
        .POLL_GAP    (POLL_GAP),
        .POLL_LIMIT  (24'd4)
    ) dut (
        .CLK      (CLK),
        .reset_n  (reset_n),
        .op_req   (op_req),
        .op_code  (op_code),
        .op_addr  (op_addr),
        .seq_busy (seq_busy),
        .op_done  (op_done),
        .op_error (op_error),
        .op_result(op_result),
        .mem      (mem_if.master)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Controller model state, configured by the tests.
    bit          model_en = 1'b1;
    int          busy_len = 3;
    logic [47:0] rdid_data = 48'h0;
    logic [7:0]  rsr_default = 8'h00;
    logic [7:0]  rsr_q[$];
    logic [7:0]  cmd_log[$];
    logic [23:0] addr_log[$];
    int          cyc_log[$];

    initial begin
        logic        trig_prev;
        int          busy_cnt;
        logic [47:0] resp;
        trig_prev = 1'b0;
        busy_cnt  = 0;
        resp      = '0;
        mem_if.MEM_CTRL_busy = 1'b0;
        mem_if.MEMDATA       = '0;
        forever begin
            @(negedge CLK);
            if (mem_if.MEMTRIG === 1'b1 && !trig_prev) begin
                cmd_log.push_back(mem_if.MEMCMD);
                addr_log.push_back(mem_if.MEMADDR);
                cyc_log.push_back(cyc);
                if (model_en) begin
                    if (mem_if.MEMCMD == 8'h9F) resp = rdid_data;
                    else if (mem_if.MEMCMD == 8'h05)
                        resp = {40'h0, (rsr_q.size() > 0) ? rsr_q.pop_front() : rsr_default};
                    else resp = '0;
                    busy_cnt = busy_len;
                    mem_if.MEM_CTRL_busy = 1'b1;
                end
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    mem_if.MEM_CTRL_busy = 1'b0;
                    mem_if.MEMDATA       = resp;
                end
            end
            trig_prev = (mem_if.MEMTRIG === 1'b1);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic clear_log();
        cmd_log.delete();
        addr_log.delete();
        cyc_log.delete();
        rsr_q.delete();
    endtask

    task automatic request(input logic [1:0] code, input logic [23:0] addr);
        @(negedge CLK);
        op_req  = 1'b1;
        op_code = code;
        op_addr = addr;
        @(negedge CLK);
        op_req  = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles, output bit seen);
        int n;
        seen = 1'b0;
        n = 0;
        while (!seen && n < max_cycles) begin
            if (op_done === 1'b1) seen = 1'b1;
            else begin
                @(negedge CLK);
                n++;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(3);
        checks++; if (seq_busy !== 1'b0) begin failures++; $display("FAIL reset_seq_busy got=%b exp=0", seq_busy); end
        checks++; if (op_done !== 1'b0) begin failures++; $display("FAIL reset_op_done got=%b exp=0", op_done); end
        checks++; if (op_error !== 1'b0) begin failures++; $display("FAIL reset_op_error got=%b exp=0", op_error); end
        checks++; if (op_result !== 48'h0) begin failures++; $display("FAIL reset_op_result got=%h exp=0", op_result); end
        checks++; if (mem_if.MEMCMD !== 8'h00) begin failures++; $display("FAIL reset_memcmd got=%h exp=00", mem_if.MEMCMD); end
        checks++; if (mem_if.MEMADDR !== 24'h0) begin failures++; $display("FAIL reset_memaddr got=%h exp=0", mem_if.MEMADDR); end
        checks++; if (mem_if.MEMTRIG !== 1'b0) begin failures++; $display("FAIL reset_memtrig got=%b exp=0", mem_if.MEMTRIG); end
        checks++; if (mem_if.MEMVAL !== 24'h0 || mem_if.MEMQUAD !== 1'b0) begin failures++; $display("FAIL reset_const got=%h/%b exp=0/0", mem_if.MEMVAL, mem_if.MEMQUAD); end
        reset_n = 1'b1;
        tick(2);
        $display("test_reset: done");
    endtask

    task automatic test_rdid();
        bit seen;
        clear_log();
        model_en  = 1'b1;
        busy_len  = 8;
        rdid_data = 48'h0102_1940_0000;
        request(2'b00, 24'h0);
        checks++; if (seq_busy !== 1'b1) begin failures++; $display("FAIL rdid_busy_after_accept got=%b exp=1", seq_busy); end
        // a second request while busy must be ignored
        tick(2);
        op_req = 1'b1; op_code = 2'b01;
        tick(1);
        op_req = 1'b0;
        wait_done(200, seen);
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL rdid_done_timeout got=%b exp=1", seen); end
        checks++; if (op_error !== 1'b0) begin failures++; $display("FAIL rdid_error got=%b exp=0", op_error); end
        checks++; if (op_result !== 48'h0102_1940_0000) begin failures++; $display("FAIL rdid_result got=%h exp=010219400000", op_result); end
        checks++; if (seq_busy !== 1'b0) begin failures++; $display("FAIL rdid_busy_at_done got=%b exp=0", seq_busy); end
        checks++; if (cmd_log.size() != 1) begin failures++; $display("FAIL rdid_trigger_count got=%0d exp=1", cmd_log.size()); end
        else begin
            checks++; if (cmd_log[0] !== 8'h9F) begin failures++; $display("FAIL rdid_cmd got=%h exp=9F", cmd_log[0]); end
        end
        tick(1);
        checks++; if (op_done !== 1'b0) begin failures++; $display("FAIL rdid_done_pulse_width got=%b exp=0", op_done); end
        $display("test_rdid: triggers=%0d result=%h", cmd_log.size(), op_result);
        tick(3);
    endtask

    task automatic test_sector_erase();
        bit seen;
        logic [7:0] exp[$];
        int d8_idx;
        clear_log();
        busy_len = 3;
        rsr_default = 8'hFF;
`ifdef FLASH_SEQ_WEL_CHECK_EN
        exp = '{8'h06, 8'h05, 8'hD8, 8'h05, 8'h05, 8'h05};
        rsr_q.push_back(8'h02);
`else
        exp = '{8'h06, 8'hD8, 8'h05, 8'h05, 8'h05};
`endif
        rsr_q.push_back(8'h03);
        rsr_q.push_back(8'h03);
        rsr_q.push_back(8'h00);
        d8_idx = exp.size() - 4;
        request(2'b10, 24'h010000);
        wait_done(2000, seen);
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL se_done_timeout got=%b exp=1", seen); end
        checks++; if (op_error !== 1'b0) begin failures++; $display("FAIL se_error got=%b exp=0", op_error); end
        checks++; if (op_result !== 48'h0) begin failures++; $display("FAIL se_result got=%h exp=0", op_result); end
        checks++; if (cmd_log.size() != exp.size()) begin failures++; $display("FAIL se_cmd_count got=%0d exp=%0d", cmd_log.size(), exp.size()); end
        else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++; if (cmd_log[i] !== exp[i]) begin failures++; $display("FAIL se_cmd[%0d] got=%h exp=%h", i, cmd_log[i], exp[i]); end
            end
            checks++; if (addr_log[d8_idx] !== 24'h010000) begin failures++; $display("FAIL se_addr got=%h exp=010000", addr_log[d8_idx]); end
            for (int i = d8_idx + 2; i < exp.size(); i++) begin
                checks++; if (cyc_log[i] - cyc_log[i-1] < POLL_GAP) begin failures++; $display("FAIL se_poll_gap[%0d] got=%0d exp>=%0d", i, cyc_log[i] - cyc_log[i-1], POLL_GAP); end
            end
        end
        $display("test_sector_erase: triggers=%0d error=%b", cmd_log.size(), op_error);
        tick(3);
    endtask

    task automatic test_bulk_wel();
        bit seen;
        logic [7:0] exp[$];
        logic       exp_err;
        clear_log();
        rsr_default = 8'h00;
`ifdef FLASH_SEQ_WEL_CHECK_EN
        exp = '{8'h06, 8'h05, 8'h06, 8'h05, 8'h06, 8'h05};
        exp_err = 1'b1;
`else
        exp = '{8'h06, 8'hC7, 8'h05};
        exp_err = 1'b0;
`endif
        request(2'b11, 24'hABCDEF);
        wait_done(1000, seen);
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL be_done_timeout got=%b exp=1", seen); end
        checks++; if (op_error !== exp_err) begin failures++; $display("FAIL be_error got=%b exp=%b", op_error, exp_err); end
        checks++; if (cmd_log.size() != exp.size()) begin failures++; $display("FAIL be_cmd_count got=%0d exp=%0d", cmd_log.size(), exp.size()); end
        else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++; if (cmd_log[i] !== exp[i]) begin failures++; $display("FAIL be_cmd[%0d] got=%h exp=%h", i, cmd_log[i], exp[i]); end
                if (exp[i] == 8'hC7) begin
                    checks++; if (addr_log[i] !== 24'h0) begin failures++; $display("FAIL be_addr got=%h exp=0", addr_log[i]); end
                end
            end
        end
        $display("test_bulk_wel: triggers=%0d error=%b", cmd_log.size(), op_error);
        tick(3);
    endtask

    task automatic test_busy_timeout();
        bit seen;
        int high_cnt;
        int n;
        clear_log();
        model_en = 1'b0;
        request(2'b00, 24'h0);
        n = 0;
        while (mem_if.MEMTRIG !== 1'b1 && n < 10) begin
            @(negedge CLK);
            n++;
        end
        checks++; if (mem_if.MEMTRIG !== 1'b1) begin failures++; $display("FAIL to_trigger_rise got=%b exp=1", mem_if.MEMTRIG); end
        high_cnt = 0;
        while (mem_if.MEMTRIG === 1'b1 && high_cnt < 100) begin
            high_cnt++;
            @(negedge CLK);
        end
        checks++; if (high_cnt != BUSY_TIMEOUT) begin failures++; $display("FAIL to_trigger_width got=%0d exp=%0d", high_cnt, BUSY_TIMEOUT); end
        checks++; if (op_error !== 1'b1) begin failures++; $display("FAIL to_error_at_drop got=%b exp=1", op_error); end
        wait_done(10, seen);
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL to_done_timeout got=%b exp=1", seen); end
        checks++; if (op_error !== 1'b1) begin failures++; $display("FAIL to_error_at_done got=%b exp=1", op_error); end
        checks++; if (cmd_log.size() != 1) begin failures++; $display("FAIL to_trigger_count got=%0d exp=1", cmd_log.size()); end
        model_en = 1'b1;
        $display("test_busy_timeout: trig_width=%0d error=%b", high_cnt, op_error);
        tick(3);
    endtask

    task automatic test_poll_limit();
        bit seen;
        int polls;
        int exp_size;
        clear_log();
        rsr_default = 8'h03;
`ifdef FLASH_SEQ_WEL_CHECK_EN
        exp_size = 7;
`else
        exp_size = 6;
`endif
        request(2'b10, 24'h020000);
        wait_done(3000, seen);
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL pl_done_timeout got=%b exp=1", seen); end
        checks++; if (op_error !== 1'b1) begin failures++; $display("FAIL pl_error got=%b exp=1", op_error); end
        checks++; if (cmd_log.size() != exp_size) begin failures++; $display("FAIL pl_cmd_count got=%0d exp=%0d", cmd_log.size(), exp_size); end
        polls = 0;
        for (int i = exp_size - 4; i < cmd_log.size(); i++) if (cmd_log[i] == 8'h05) polls++;
        checks++; if (polls != 4) begin failures++; $display("FAIL pl_poll_count got=%0d exp=4", polls); end
        $display("test_poll_limit: polls=%0d error=%b", polls, op_error);
        tick(3);
    endtask

    task automatic test_reset_mid_op();
        bit seen;
        bit found;
        int n;
        int log_size;
        clear_log();
        rsr_default = 8'h03;
        request(2'b10, 24'h030000);
        found = 1'b0;
        n = 0;
        while (!found && n < 200) begin
            if (cmd_log.size() > 0 && cmd_log[cmd_log.size()-1] == 8'hD8) found = 1'b1;
            else begin
                @(negedge CLK);
                n++;
            end
        end
        checks++; if (found !== 1'b1) begin failures++; $display("FAIL rm_erase_seen got=%b exp=1", found); end
        n = 0;
        while (mem_if.MEM_CTRL_busy === 1'b1 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        tick(10);
        checks++; if (seq_busy !== 1'b1) begin failures++; $display("FAIL rm_busy_in_gap got=%b exp=1", seq_busy); end
        reset_n = 1'b0;
        tick(1);
        checks++; if (mem_if.MEMTRIG !== 1'b0) begin failures++; $display("FAIL rm_memtrig got=%b exp=0", mem_if.MEMTRIG); end
        checks++; if (seq_busy !== 1'b0) begin failures++; $display("FAIL rm_seq_busy got=%b exp=0", seq_busy); end
        reset_n = 1'b1;
        log_size = cmd_log.size();
        tick(100);
        checks++; if (cmd_log.size() != log_size) begin failures++; $display("FAIL rm_idle_after_reset got=%0d exp=%0d", cmd_log.size(), log_size); end
        clear_log();
        busy_len  = 4;
        rdid_data = 48'hAABB_CCDD_EEFF;
        request(2'b00, 24'h0);
        wait_done(200, seen);
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL rm_rdid_done got=%b exp=1", seen); end
        checks++; if (op_error !== 1'b0) begin failures++; $display("FAIL rm_rdid_error got=%b exp=0", op_error); end
        checks++; if (op_result !== 48'hAABB_CCDD_EEFF) begin failures++; $display("FAIL rm_rdid_result got=%h exp=AABBCCDDEEFF", op_result); end
        checks++; if (cmd_log.size() != 1 || cmd_log[0] !== 8'h9F) begin failures++; $display("FAIL rm_rdid_cmd got_count=%0d exp=1 with 9F", cmd_log.size()); end
        $display("test_reset_mid_op: result=%h error=%b", op_result, op_error);
        tick(3);
    endtask

    initial begin
        test_reset();
        test_rdid();
        test_sector_erase();
        test_bulk_wel();
        test_busy_timeout();
        test_poll_limit();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "global timeout");
    end
endmodule

// File: doc/flash_op_sequencer.md
Name: flash_op_sequencer

Overview:
- Sequences multi-command flash operations (sector/bulk erase) on the existing quad-flash memory controller through its MEMCMD/MEMTRIG/MEM_CTRL_busy handshake.
- Inserts WREN before erase, optionally checks WEL, polls RSR1 for WIP=0, and reports done/error/result to one upstream requester.
- Sits between the application logic and the memory controller; it is the only block that drives MEMTRIG.

Parameters:
- BUSY_TIMEOUT, 16: cycles allowed between MEMTRIG rise and MEM_CTRL_busy rise before error.
- POLL_GAP, 64: idle cycles between consecutive RSR1 polls (16-bit counter).
- POLL_LIMIT, 24'hFFFFFF: maximum RSR1 polls per erase before error.
- WEL_RETRIES, 3: WREN attempts before error (2-bit counter).
- WIP_BIT, 0: bit index of WIP in MEMDATA[7:0].
- WEL_BIT, 1: bit index of WEL in MEMDATA[7:0].

Ports:
- CLK  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- op_req  in  1  start request; sampled only in IDLE
- op_code  in  2  00 RDID, 01 RSR1, 10 sector erase, 11 bulk erase
- op_addr  in  24  sector address for sector erase
- seq_busy  out  1  high from accept until op_done
- op_done  out  1  one-cycle completion pulse
- op_error  out  1  valid with op_done; held until next accept
- op_result  out  48  MEMDATA captured at the final command
- MEMCMD  out  8  command to memory controller
- MEMADDR  out  24  address to memory controller
- MEMVAL  out  24  constant 0
- MEMQUAD  out  1  constant 0
- MEMTRIG  out  1  trigger to memory controller
- MEM_CTRL_busy  in  1  memory controller busy
- MEMDATA  in  48  memory controller read data

Behaviour:
- Interface: one clock, CLK; reset is synchronous and active-low, reset_n.
- Reset values: seq_busy 0, op_done 0, op_error 0, op_result 0, MEMCMD 0, MEMADDR 0, MEMTRIG 0, all counters 0, state IDLE.
- Reset mid-operation drops MEMTRIG the next edge and abandons the sequence. The memory controller is not reset by this block.
- Command handshake (ISSUE → WAIT_ACK → WAIT_DONE):
  - ISSUE: drive MEMCMD/MEMADDR and set MEMTRIG=1.
  - WAIT_ACK: hold MEMTRIG until MEM_CTRL_busy=1, then clear MEMTRIG. If BUSY_TIMEOUT cycles elapse without busy, clear MEMTRIG and FINISH with error.
  - WAIT_DONE: wait for MEM_CTRL_busy=0, then sample MEMDATA and go to DECIDE.
  - MEMTRIG is never high in WAIT_DONE; this prevents retriggering.
- Accept: in IDLE with op_req=1 and MEM_CTRL_busy=0. Latch op_code and op_addr, set seq_busy=1, clear op_error. op_req while busy is ignored.
- Step sequences:
  - RDID: single command 8'h9F.
  - RSR1: single command 8'h05.
  - Sector erase: WREN 8'h06 → [WELCHK 8'h05] → SE 8'hD8 with latched address → POLL.
  - Bulk erase: same sequence with BE 8'hC7, MEMADDR=0.
- DECIDE rules:
  - WELCHK: MEMDATA[WEL_BIT]=1 → erase step. Otherwise, if fewer than WEL_RETRIES attempts → WREN again; else FINISH with error.
  - POLL: MEMDATA[WIP_BIT]=0 → FINISH ok. Otherwise increment poll count; if count equals POLL_LIMIT → FINISH with error; else GAP for POLL_GAP cycles, then reissue RSR1.
  - Erase step is followed by GAP and then the first RSR1 poll.
  - Single-command ops → FINISH ok.
- FINISH: op_result <= last sampled MEMDATA, op_done=1 for one cycle, seq_busy=0 in the same cycle, return to IDLE.
- Minimum latency, single command with ideal controller: accept → op_done within 2 + ack + done cycles. No back-to-back accept in the op_done cycle.

Optional Feature:
- FLASH_SEQ_WEL_CHECK_EN defined: the WELCHK step and retry logic are present.
- Undefined: WREN is followed directly by the erase command, WEL_RETRIES is unused, and the WEL error path cannot occur.

Test Plan:
- op_code=00, controller model busy for 8 cycles, MEMDATA=48'h0102_1940_0000 → one MEMCMD=8'h9F trigger, op_done with op_error=0, op_result=48'h0102_1940_0000.
- Sector erase at 24'h010000, WEL=1, WIP reads 1,1,0 → command order 06,05,D8,05,05,05; MEMADDR=24'h010000 on D8; op_error=0; at least POLL_GAP idle cycles between polls.
- Bulk erase, RSR1 always returns 8'h00 (WEL=0) with WEL check enabled → three WREN/RSR1 pairs, no C7 issued, op_done with op_error=1.
- MEM_CTRL_busy never rises after MEMTRIG → MEMTRIG clears and op_error=1 exactly BUSY_TIMEOUT=16 cycles after trigger.
- POLL_LIMIT=4, WIP stuck at 1 → exactly 4 polls, then op_done with op_error=1.
- reset_n=0 during the POLL GAP → next edge: MEMTRIG=0, seq_busy=0, state IDLE; a new RDID request afterwards completes normally.
